jeff_74x161_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of a 74x161 4-bit counter.

---
 rtl/jeff_74x161_ctrl.sv | 99 +++++++++
 tb/tb_jeff_74x161_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/jeff_74x161_ctrl.sv
// Sequencer driving a 74x161 counter: loads a preset, runs the counter
// modulo-(16-preset) for a programmed number of wraps, then flags done.
module jeff_74x161_ctrl #(
  parameter int unsigned WRAP_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [3:0]        preset,
  input  logic [WRAP_W-1:0] wraps,
  input  logic              rco,
  output logic              ld,
  output logic              ent,
  output logic              enp,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [3:0]        pre_q;
  logic [WRAP_W-1:0] wraps_q;
  logic [WRAP_W-1:0] cnt_nxt;
  logic              tc;

  assign tc      = rco & ~pause;
  // wraps==0 needs no special case: cnt_nxt rolls over to 0 after 2**WRAP_W wraps
  assign cnt_nxt = wrap_cnt + WRAP_W'(1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      pre_q    <= '0;
      wraps_q  <= '0;
      wrap_cnt <= '0;
    end else if (abort) begin
      state    <= S_IDLE;
      wraps_q  <= '0;
      wrap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            pre_q    <= preset;
            wraps_q  <= wraps;
            wrap_cnt <= '0;
          end
        end
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          if (tc) begin
            wrap_cnt <= cnt_nxt;
            if (cnt_nxt == wraps_q) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld   = 1'b1;
    ent  = 1'b0;
    enp  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_LOAD: begin
        ld   = 1'b0;
        ent  = 1'b1;
        busy = 1'b1;
      end
      S_RUN: begin
        // rco feeds straight through to LOAD, like a hard-wired modulo counter
        ld   = ~tc;
        ent  = 1'b1;
        enp  = ~pause;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign {d, c, b, a} = pre_q;

endmodule

// File: tb/tb_jeff_74x161_ctrl.sv
// Directed bench for jeff_74x161_ctrl driving a behavioural 74x161 model.
module tb_jeff_74x161_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       start, pause, abort;
  logic [3:0] preset;
  logic [3:0] wraps;
  logic       rco;
  logic       ld, ent, enp, a, b, c, d, busy, done;
  logic [3:0] wrap_cnt;
  logic [3:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  jeff_74x161_ctrl #(.WRAP_W(4)) dut (
    .clk(clk), .clr(clr), .start(start), .pause(pause), .abort(abort),
    .preset(preset), .wraps(wraps), .rco(rco),
    .ld(ld), .ent(ent), .enp(enp), .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  // 74x161 behavioural model (clear pin tied inactive)
  initial q = 4'h0;
  assign rco = ent & (q == 4'hF);
  always @(posedge clk) begin
    if (!ld)             q <= {d, c, b, a};
    else if (ent && enp) q <= q + 4'h1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [3:0] p, input logic [3:0] w);
    preset = p;
    wraps  = w;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    logic [3:0] seq2 [8];
    seq2 = '{4'hD, 4'hE, 4'hF, 4'hC, 4'hD, 4'hE, 4'hF, 4'hC};
    clr = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    preset = 4'h0; wraps = 4'h0;

    // reset state
    #2;
    chk("rst_ld", ld, 1);
    chk("rst_en", {ent, enp}, 0);
    chk("rst_data", {d, c, b, a}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_wcnt", wrap_cnt, 0);
    #10 clr = 1'b1;

    // preset C, two wraps
    tick();
    arm(4'hC, 4'd2);
    chk("t2_load_ld", ld, 0);
    chk("t2_load_en", {ent, enp}, 2'b10);
    chk("t2_load_busy", busy, 1);
    chk("t2_load_data", {d, c, b, a}, 4'hC);
    tick();
    chk("t2_q_first", q, 4'hC);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_q_seq", q, seq2[i]);
      if (i == 2) chk("t2_ld_tc", ld, 0);
      if (i == 3) chk("t2_wcnt1", wrap_cnt, 1);
    end
    chk("t2_done", done, 1);
    chk("t2_wcnt", wrap_cnt, 2);
    chk("t2_en_off", {ent, enp, busy}, 0);
    tick();
    chk("t2_rest", q, 4'hC);

    // start in DONE with preset 3
    arm(4'h3, 4'd1);
    chk("t6b_state", {done, busy, ld}, 3'b010);
    chk("t6b_data", {d, c, b, a}, 4'b0011);
    chk("t6b_wcnt", wrap_cnt, 0);
    wait_done("t6b_done", 30);
    chk("t6b_wcnt_end", wrap_cnt, 1);
    chk("t6b_rest", q, 4'h3);

    // pause while at terminal count
    arm(4'hE, 4'd2);
    tick();
    chk("t3_q_e", q, 4'hE);
    tick();
    chk("t3_q_f", q, 4'hF);
    pause = 1'b1;
    #1;
    chk("t3_pause_ld", ld, 1);
    chk("t3_pause_enp", enp, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_q", q, 4'hF);
      chk("t3_hold_wcnt", wrap_cnt, 0);
      chk("t3_hold_ld", ld, 1);
    end
    pause = 1'b0;
    #1;
    chk("t3_release_ld", ld, 0);
    tick();
    chk("t3_reload_q", q, 4'hE);
    chk("t3_reload_wcnt", wrap_cnt, 1);
    wait_done("t3_done", 10);
    chk("t3_wcnt_end", wrap_cnt, 2);

    // start during RUN is ignored
    arm(4'hD, 4'd1);
    tick();
    preset = 4'h0; wraps = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6a_q_e", q, 4'hE);
    chk("t6a_busy", busy, 1);
    tick();
    tick();
    chk("t6a_done", done, 1);
    chk("t6a_wcnt", wrap_cnt, 1);
    chk("t6a_data", {d, c, b, a}, 4'hD);
    chk("t6a_rest", q, 4'hD);

    // preset F, wraps=0 -> 16 wraps
    arm(4'hF, 4'd0);
    tick();
    chk("t4_q_f", q, 4'hF);
    chk("t4_rco", rco, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) begin
        chk("t4_wcnt", wrap_cnt, i);
        chk("t4_not_done", done, 0);
      end
    end
    chk("t4_done", done, 1);
    chk("t4_wcnt_end", wrap_cnt, 0);
    chk("t4_rest", q, 4'hF);

    // abort with start from DONE, then both in IDLE
    abort = 1'b1; start = 1'b1; preset = 4'h6;
    tick();
    chk("t5a_idle", {busy, done, ld}, 3'b001);
    chk("t5a_data_hold", {d, c, b, a}, 4'hF);
    tick();
    abort = 1'b0; start = 1'b0;
    chk("t5a_stay_idle", {busy, ent, ld}, 3'b001);

    // abort mid-RUN
    arm(4'h5, 4'd3);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5b_idle", {busy, ent, enp, ld}, 4'b0001);
    chk("t5b_wcnt", wrap_cnt, 0);
    chk("t5b_data", {d, c, b, a}, 4'h5);

    // async clear during RUN at count E
    arm(4'hA, 4'd2);
    for (int i = 0; i < 5; i++) tick();
    chk("t1_q_e", q, 4'hE);
    #2 clr = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_en", {ent, enp}, 0);
    chk("t1_ld", ld, 1);
    chk("t1_data", {d, c, b, a}, 0);
    #3 clr = 1'b1;
    tick();
    chk("t1_idle", {busy, done}, 0);
    chk("t1_q_hold", q, 4'hE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
